// File: rtl/riscv_int_controller_mc.sv
// rtl/riscv_int_controller_mc.sv - multi-line interrupt controller with req/ack/kill handshake to the core
//
// Purpose:
//   Collects N_IRQ interrupt lines. Each line is level or rising-edge, maskable and secure/non-secure.
//   Edge events are latched in a pending register. The controller picks the lowest-index eligible line
//   and presents it to the core controller.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   irq_i                 raw interrupt lines
//   irq_edge_i            per-line mode (1 = rising edge, 0 = level)
//   irq_en_i              per-line enable mask
//   irq_sec_i             per-line secure attribute
//   m_IE_i, u_IE_i        global M/U interrupt enables
//   current_priv_lvl_i    2'b00 = U, 2'b11 = M
//   irq_req_ctrl_o        request to the controller (high while a request is pending)
//   irq_sec_ctrl_o        secure bit of the captured request
//   irq_id_ctrl_o         ID of the captured request
//   ctrl_ack_i            controller accepted the request
//   ctrl_kill_i           controller withdrew the request
//   irq_ack_o             one-cycle pulse when the interrupt is taken
//   irq_ack_id_o          ID for irq_ack_o
//   irq_pending_o         edge-pending register
module riscv_int_controller_mc #(
    parameter int N_IRQ       = 32,
    parameter int ID_W        = 5,
    parameter bit PULP_SECURE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic [N_IRQ-1:0] irq_edge_i,
    input  logic [N_IRQ-1:0] irq_en_i,
    input  logic [N_IRQ-1:0] irq_sec_i,
    input  logic             m_IE_i,
    input  logic             u_IE_i,
    input  logic [1:0]       current_priv_lvl_i,
    output logic             irq_req_ctrl_o,
    output logic             irq_sec_ctrl_o,
    output logic [ID_W-1:0]  irq_id_ctrl_o,
    input  logic             ctrl_ack_i,
    input  logic             ctrl_kill_i,
    output logic             irq_ack_o,
    output logic [ID_W-1:0]  irq_ack_id_o,
    output logic [N_IRQ-1:0] irq_pending_o
);

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_M = 2'b11;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        IRQ_PENDING = 2'd1,
        IRQ_DONE    = 2'd2
    } state_t;

    state_t           state;
    logic [N_IRQ-1:0] irq_q;
    logic [N_IRQ-1:0] pend_q;
    logic [ID_W-1:0]  id_q;
    logic             sec_q;

    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] set_vec;
    logic [N_IRQ-1:0] clr_vec;
    logic [N_IRQ-1:0] act;
    logic [N_IRQ-1:0] gate;
    logic [N_IRQ-1:0] cand;
    logic [ID_W-1:0]  win_id;
    logic             win_sec;

    assign rise    = irq_i & ~irq_q;
    assign set_vec = irq_edge_i & rise;

    // An edge line is active on its pending bit or on the edge itself, so a fresh
    // edge is seen in the same cycle a level line would be.
    assign act = (irq_edge_i & (pend_q | rise)) | (~irq_edge_i & irq_i);

    generate
        if (PULP_SECURE) begin : g_secure_gate
            // In U mode secure lines ignore u_IE; privilege encodings 01/10 gate everything off.
            assign gate = ({N_IRQ{current_priv_lvl_i == PRIV_U}} & ({N_IRQ{u_IE_i}} | irq_sec_i))
                        | {N_IRQ{(current_priv_lvl_i == PRIV_M) & m_IE_i}};
        end else begin : g_plain_gate
            assign gate = {N_IRQ{m_IE_i}};
        end
    endgenerate

    assign cand = act & irq_en_i & gate;

    // Fixed priority: iterate from the top so the lowest set index is written last.
    always_comb begin
        win_id  = '0;
        win_sec = 1'b0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_id  = ID_W'(i);
                win_sec = irq_sec_i[i];
            end
        end
    end

    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            clr_vec[i] = (state == IRQ_DONE) && (id_q == ID_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            irq_q        <= '0;
            pend_q       <= '0;
            id_q         <= '0;
            sec_q        <= 1'b0;
            irq_ack_o    <= 1'b0;
            irq_ack_id_o <= '0;
        end else begin
            irq_q  <= irq_i;
            // Set after clear: a new edge on the acknowledged line survives.
            pend_q <= (pend_q & ~clr_vec) | set_vec;
            case (state)
                IDLE: begin
                    irq_ack_o <= 1'b0;
                    if (|cand) begin
                        state <= IRQ_PENDING;
                        id_q  <= win_id;
                        sec_q <= win_sec;
                    end
                end
                IRQ_PENDING: begin
                    // Ack has priority over kill; captured id/sec stay frozen here.
                    if (ctrl_ack_i) begin
                        state        <= IRQ_DONE;
                        irq_ack_o    <= 1'b1;
                        irq_ack_id_o <= id_q;
                    end else if (ctrl_kill_i) begin
                        state <= IDLE;
                    end
                end
                IRQ_DONE: begin
                    irq_ack_o <= 1'b0;
                    sec_q     <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    irq_ack_o <= 1'b0;
                end
            endcase
        end
    end

    assign irq_req_ctrl_o = (state == IRQ_PENDING);
    assign irq_sec_ctrl_o = sec_q;
    assign irq_id_ctrl_o  = id_q;
    assign irq_pending_o  = pend_q;

endmodule

// File: tb/tb_riscv_int_controller_mc.sv
// tb/tb_riscv_int_controller_mc.sv - directed self-checking bench for riscv_int_controller_mc
module tb_riscv_int_controller_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] irq, irq_edge, irq_en, irq_sec;
    logic        m_ie, u_ie;
    logic [1:0]  priv;
    logic        req, sec_o, ack_o;
    logic [4:0]  id_o, ack_id;
    logic        ack, kill;
    logic [31:0] pend;

    int total  = 0;
    int passed = 0;

    riscv_int_controller_mc #(.N_IRQ(32), .ID_W(5), .PULP_SECURE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .irq_i(irq), .irq_edge_i(irq_edge), .irq_en_i(irq_en),
        .irq_sec_i(irq_sec), .m_IE_i(m_ie), .u_IE_i(u_ie), .current_priv_lvl_i(priv),
        .irq_req_ctrl_o(req), .irq_sec_ctrl_o(sec_o), .irq_id_ctrl_o(id_o),
        .ctrl_ack_i(ack), .ctrl_kill_i(kill), .irq_ack_o(ack_o), .irq_ack_id_o(ack_id),
        .irq_pending_o(pend)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic base_inputs();
        irq = '0; irq_edge = '0; irq_en = '1; irq_sec = '0;
        m_ie = 1'b1; u_ie = 1'b0; priv = 2'b11; ack = 1'b0; kill = 1'b0;
    endtask

    task automatic settle();
        base_inputs();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        base_inputs();
        rst_n = 1'b0;
        irq = 32'hFFFF_FFFF;
        repeat (2) tick();
        total++; if (req !== 1'b0)  $display("FAIL rst_req act=%0b exp=0", req);  else passed++;
        total++; if (ack_o !== 1'b0) $display("FAIL rst_ack act=%0b exp=0", ack_o); else passed++;
        total++; if (pend !== 32'h0) $display("FAIL rst_pend act=%h exp=0", pend); else passed++;
        total++; if ({sec_o, id_o, ack_id} !== 11'h0) $display("FAIL rst_ids act=%h exp=0", {sec_o, id_o, ack_id}); else passed++;
        irq = '0;
        rst_n = 1'b1;
        settle();
    endtask

    task automatic test_level();
        irq[3] = 1'b1;                                   // cycle 0
        total++; if (req !== 1'b0) $display("FAIL lvl_req_c0 act=%0b exp=0", req); else passed++;
        tick();                                          // cycle 1
        total++; if (req !== 1'b1 || id_o !== 5'd3) $display("FAIL lvl_req_c1 act=%0b/%0d exp=1/3", req, id_o); else passed++;
        tick();                                          // cycle 2
        ack = 1'b1; irq[3] = 1'b0;
        total++; if (req !== 1'b1) $display("FAIL lvl_hold_c2 act=%0b exp=1", req); else passed++;
        tick();                                          // cycle 3
        ack = 1'b0;
        total++; if (ack_o !== 1'b1 || ack_id !== 5'd3) $display("FAIL lvl_ack_c3 act=%0b/%0d exp=1/3", ack_o, ack_id); else passed++;
        total++; if (req !== 1'b0) $display("FAIL lvl_req_c3 act=%0b exp=0", req); else passed++;
        tick();
        total++; if (ack_o !== 1'b0) $display("FAIL lvl_ack_pulse act=%0b exp=0", ack_o); else passed++;
        settle();
    endtask

    task automatic test_priority();
        irq[7] = 1'b1; irq[2] = 1'b1;                    // cycle 0
        tick();                                          // cycle 1
        total++; if (req !== 1'b1 || id_o !== 5'd2) $display("FAIL pri_first act=%0b/%0d exp=1/2", req, id_o); else passed++;
        ack = 1'b1; irq[2] = 1'b0;
        tick();                                          // cycle 2: DONE
        ack = 1'b0;
        total++; if (ack_o !== 1'b1 || ack_id !== 5'd2) $display("FAIL pri_ack2 act=%0b/%0d exp=1/2", ack_o, ack_id); else passed++;
        tick();                                          // cycle 3: IDLE
        total++; if (req !== 1'b0) $display("FAIL pri_gap act=%0b exp=0", req); else passed++;
        tick();                                          // cycle 4
        total++; if (req !== 1'b1 || id_o !== 5'd7) $display("FAIL pri_second act=%0b/%0d exp=1/7", req, id_o); else passed++;
        ack = 1'b1; irq[7] = 1'b0;
        tick();
        ack = 1'b0;
        total++; if (ack_o !== 1'b1 || ack_id !== 5'd7) $display("FAIL pri_ack7 act=%0b/%0d exp=1/7", ack_o, ack_id); else passed++;
        settle();
    endtask

    task automatic test_edge_kill();
        m_ie = 1'b0; irq_edge[5] = 1'b1;
        irq[5] = 1'b1;                                   // cycle 0: pulse
        tick();
        irq[5] = 1'b0;
        total++; if (pend[5] !== 1'b1 || req !== 1'b0) $display("FAIL edge_latch act=%0b/%0b exp=1/0", pend[5], req); else passed++;
        tick();
        total++; if (req !== 1'b0) $display("FAIL edge_masked act=%0b exp=0", req); else passed++;
        m_ie = 1'b1;
        tick();
        total++; if (req !== 1'b1 || id_o !== 5'd5) $display("FAIL edge_req act=%0b/%0d exp=1/5", req, id_o); else passed++;
        kill = 1'b1;
        tick();
        kill = 1'b0;
        total++; if (req !== 1'b0 || pend[5] !== 1'b1) $display("FAIL edge_kill act=%0b/%0b exp=0/1", req, pend[5]); else passed++;
        tick();
        total++; if (req !== 1'b1 || id_o !== 5'd5) $display("FAIL edge_rereq act=%0b/%0d exp=1/5", req, id_o); else passed++;
        ack = 1'b1;
        tick();                                          // DONE
        ack = 1'b0;
        total++; if (ack_o !== 1'b1 || ack_id !== 5'd5) $display("FAIL edge_ack act=%0b/%0d exp=1/5", ack_o, ack_id); else passed++;
        tick();
        total++; if (pend[5] !== 1'b0 || req !== 1'b0) $display("FAIL edge_clear act=%0b/%0b exp=0/0", pend[5], req); else passed++;
        settle();
    endtask

    task automatic test_secure();
        priv = 2'b00; u_ie = 1'b0;
        irq[4] = 1'b1;
        repeat (2) tick();
        total++; if (req !== 1'b0) $display("FAIL sec_nonsec_blocked act=%0b exp=0", req); else passed++;
        irq[4] = 1'b0;
        irq[6] = 1'b1; irq_sec[6] = 1'b1;
        tick();
        total++; if (req !== 1'b1 || id_o !== 5'd6 || sec_o !== 1'b1) $display("FAIL sec_req act=%0b/%0d/%0b exp=1/6/1", req, id_o, sec_o); else passed++;
        ack = 1'b1; irq[6] = 1'b0;
        tick();                                          // DONE
        ack = 1'b0;
        total++; if (ack_o !== 1'b1 || sec_o !== 1'b1) $display("FAIL sec_done act=%0b/%0b exp=1/1", ack_o, sec_o); else passed++;
        tick();
        total++; if (sec_o !== 1'b0) $display("FAIL sec_clear act=%0b exp=0", sec_o); else passed++;
        settle();
        priv = 2'b01; irq[1] = 1'b1; irq_sec[1] = 1'b1; u_ie = 1'b1;
        repeat (2) tick();
        total++; if (req !== 1'b0) $display("FAIL sec_priv01 act=%0b exp=0", req); else passed++;
        settle();
    endtask

    task automatic test_ack_kill();
        irq[9] = 1'b1;
        tick();
        total++; if (req !== 1'b1 || id_o !== 5'd9) $display("FAIL ak_req act=%0b/%0d exp=1/9", req, id_o); else passed++;
        ack = 1'b1; kill = 1'b1; irq[9] = 1'b0;
        tick();
        ack = 1'b0; kill = 1'b0;
        total++; if (ack_o !== 1'b1 || ack_id !== 5'd9 || req !== 1'b0) $display("FAIL ak_ackwins act=%0b/%0d/%0b exp=1/9/0", ack_o, ack_id, req); else passed++;
        settle();
        irq_edge[9] = 1'b1;
        irq[9] = 1'b1;                                   // cycle 0
        tick();
        irq[9] = 1'b0;
        total++; if (req !== 1'b1 || pend[9] !== 1'b1) $display("FAIL ak_edge_req act=%0b/%0b exp=1/1", req, pend[9]); else passed++;
        ack = 1'b1;
        tick();                                          // DONE, new edge now
        ack = 1'b0; irq[9] = 1'b1;
        tick();
        irq[9] = 1'b0;
        total++; if (pend[9] !== 1'b1) $display("FAIL ak_set_wins act=%0b exp=1", pend[9]); else passed++;
        tick();
        total++; if (req !== 1'b1 || id_o !== 5'd9) $display("FAIL ak_rereq act=%0b/%0d exp=1/9", req, id_o); else passed++;
        ack = 1'b1;
        repeat (2) tick();
        ack = 1'b0;
        total++; if (pend[9] !== 1'b0) $display("FAIL ak_final_clear act=%0b exp=0", pend[9]); else passed++;
        settle();
    endtask

    task automatic test_async_reset();
        irq[3] = 1'b1;
        tick();
        total++; if (req !== 1'b1) $display("FAIL ar_pending act=%0b exp=1", req); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (req !== 1'b0 || id_o !== 5'd0 || pend !== 32'h0) $display("FAIL ar_async act=%0b/%0d/%h exp=0/0/0", req, id_o, pend); else passed++;
        base_inputs();
        irq_edge[0] = 1'b1; irq[0] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (req !== 1'b0) $display("FAIL ar_pre_clk act=%0b exp=0", req); else passed++;
        tick();
        total++; if (req !== 1'b1 || id_o !== 5'd0 || pend[0] !== 1'b1) $display("FAIL ar_edge_after_rst act=%0b/%0d/%0b exp=1/0/1", req, id_o, pend[0]); else passed++;
        irq[0] = 1'b0; ack = 1'b1;
        repeat (2) tick();
        ack = 1'b0;
        total++; if (pend[0] !== 1'b0 || req !== 1'b0) $display("FAIL ar_cleanup act=%0b/%0b exp=0/0", pend[0], req); else passed++;
        settle();
    endtask

    initial begin
        test_reset();
        test_level();
        test_priority();
        test_edge_kill();
        test_secure();
        test_ack_kill();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
